// File: rtl/mem_arbiter_if.sv
// Bundle of requester, RAM and stall signals shared between the pipeline and the RAM arbiter.
// The arbiter connects through the slave modport; the pipeline/RAM side uses master.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_sel;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        ram_ce;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_sel;
   logic [31:0] ram_rdata;
   logic [4:0]  stall_o;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, ram_rdata,
      output if_ready, if_rdata, mem_ready, mem_rdata,
             ram_ce, ram_we, ram_addr, ram_wdata, ram_sel, stall_o
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, ram_rdata,
      input  if_ready, if_rdata, mem_ready, mem_rdata,
             ram_ce, ram_we, ram_addr, ram_wdata, ram_sel, stall_o
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and the data stage,
// with fixed MEM priority, a fixed-latency wait counter and a one-cycle ready pulse.
module mem_arbiter #(
   parameter int LATENCY = 2,
   parameter int CNT_W   = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, RESP} state_t;

   localparam logic [CNT_W-1:0] CntLoad = CNT_W'(LATENCY - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic             r_grant;
   logic             w_nextGrant;
   logic             w_grantEdge;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_ramAddr;
   logic [31:0]      r_ramWdata;
   logic [3:0]       r_ramSel;
   logic             r_ramWe;
   logic [31:0]      r_ifRdata;
   logic [31:0]      r_memRdata;
   logic             w_inAccess;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_grant <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_grant <= w_nextGrant;
      end
   end

   // Requests are only looked at in IDLE, so RESP can never re-grant a still-high request.
   always_comb begin
      w_nextState = r_state;
      w_nextGrant = r_grant;
      w_grantEdge = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.mem_req) begin
               w_nextState = MEM_ACC;
               w_nextGrant = 1'b1;
               w_grantEdge = 1'b1;
            end else if (bus.if_req) begin
               w_nextState = IF_ACC;
               w_nextGrant = 1'b0;
               w_grantEdge = 1'b1;
            end
         end
         IF_ACC, MEM_ACC: begin
            if (r_cnt == '0) w_nextState = RESP;
         end
         RESP:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_ramAddr  <= '0;
         r_ramWdata <= '0;
         r_ramSel   <= '0;
         r_ramWe    <= 1'b0;
         r_ifRdata  <= '0;
         r_memRdata <= '0;
      end else if (w_grantEdge) begin
         r_cnt <= CntLoad;
         if (w_nextGrant) begin
            r_ramAddr  <= bus.mem_addr;
            r_ramWdata <= bus.mem_wdata;
            r_ramSel   <= bus.mem_sel;
            r_ramWe    <= bus.mem_we;
         end else begin
            r_ramAddr  <= bus.if_addr;
            r_ramSel   <= 4'b1111;
            r_ramWe    <= 1'b0;
         end
      end else if (w_inAccess) begin
         if (r_cnt == '0) begin
            if (r_state == IF_ACC)
               r_ifRdata <= bus.ram_rdata;
            else if (!r_ramWe)
               r_memRdata <= bus.ram_rdata;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign w_inAccess    = (r_state == IF_ACC) || (r_state == MEM_ACC);

   assign bus.ram_ce    = w_inAccess;
   assign bus.ram_we    = (r_state == MEM_ACC) && r_ramWe;
   assign bus.ram_addr  = r_ramAddr;
   assign bus.ram_wdata = r_ramWdata;
   assign bus.ram_sel   = r_ramSel;
   assign bus.if_ready  = (r_state == RESP) && !r_grant;
   assign bus.mem_ready = (r_state == RESP) && r_grant;
   assign bus.if_rdata  = r_ifRdata;
   assign bus.mem_rdata = r_memRdata;

   // A data stall freezes pc through ex_men; a fetch stall only freezes pc and if_id.
   always_comb begin
      bus.stall_o = 5'b00000;
      if (rst) begin
         if (bus.mem_req && !bus.mem_ready)
            bus.stall_o = 5'b01111;
         else if (bus.if_req && !bus.if_ready)
            bus.stall_o = 5'b00011;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with LATENCY=2: each scenario drives its own
// vectors and checks cycle-by-cycle outputs against hand-computed values.
module tb_mem_arbiter;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   mem_arbiter_if bus ();

   mem_arbiter #(.LATENCY(2), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 2 time units after each rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst           = 1'b0;
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h60;
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h50;
      bus.mem_wdata = 32'h0;
      bus.mem_sel   = 4'hF;
      bus.ram_rdata = 32'h0;
      for (int c = 0; c < 2; c++) begin
         tick();
         total++;
         if ({bus.ram_ce, bus.ram_we, bus.if_ready, bus.mem_ready} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl cycle %0d: got %b want 0000", c,
                     {bus.ram_ce, bus.ram_we, bus.if_ready, bus.mem_ready});
         end
         total++;
         if ({bus.if_rdata, bus.mem_rdata, bus.ram_addr, bus.ram_wdata, bus.ram_sel} !== 132'd0) begin
            bad++;
            $display("[TB] FAIL reset_data cycle %0d: got %h want 0", c,
                     {bus.if_rdata, bus.mem_rdata, bus.ram_addr, bus.ram_wdata, bus.ram_sel});
         end
         total++;
         if (bus.stall_o !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL reset_stall cycle %0d: got %b want 00000", c, bus.stall_o);
         end
      end
      rst = 1'b1;
      tick();
      total++;
      if (bus.ram_ce !== 1'b1 || bus.ram_addr !== 32'h50 || bus.ram_we !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_release_grant: got ce=%b addr=%h we=%b want ce=1 addr=00000050 we=0",
                  bus.ram_ce, bus.ram_addr, bus.ram_we);
      end
      bus.if_req = 1'b0;
      tick();
      tick();
      total++;
      if (bus.mem_ready !== 1'b1 || bus.mem_rdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL reset_release_ready: got ready=%b rdata=%h want ready=1 rdata=00000000",
                  bus.mem_ready, bus.mem_rdata);
      end
      bus.mem_req = 1'b0;
      tick();
   endtask

   task automatic test_fetch();
      logic [3:0] expCe    = 4'b0110;
      logic [3:0] expReady = 4'b1000;
      logic [4:0] expStall [4] = '{5'b00011, 5'b00011, 5'b00011, 5'b00000};
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h4;
      bus.ram_rdata = 32'h3C010001;
      #1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         total++;
         if (bus.ram_ce !== expCe[c]) begin
            bad++;
            $display("[TB] FAIL fetch_ce cycle %0d: got %b want %b", c, bus.ram_ce, expCe[c]);
         end
         total++;
         if (bus.if_ready !== expReady[c] || bus.mem_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fetch_ready cycle %0d: got if=%b mem=%b want if=%b mem=0",
                     c, bus.if_ready, bus.mem_ready, expReady[c]);
         end
         total++;
         if (bus.stall_o !== expStall[c]) begin
            bad++;
            $display("[TB] FAIL fetch_stall cycle %0d: got %b want %b", c, bus.stall_o, expStall[c]);
         end
         if (expCe[c]) begin
            total++;
            if (bus.ram_addr !== 32'h4 || bus.ram_we !== 1'b0) begin
               bad++;
               $display("[TB] FAIL fetch_addr cycle %0d: got addr=%h we=%b want addr=00000004 we=0",
                        c, bus.ram_addr, bus.ram_we);
            end
         end
      end
      total++;
      if (bus.if_rdata !== 32'h3C010001) begin
         bad++;
         $display("[TB] FAIL fetch_rdata: got %h want 3c010001", bus.if_rdata);
      end
      bus.if_req = 1'b0;
      tick();
      total++;
      if (bus.ram_ce !== 1'b0 || bus.if_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL fetch_idle: got ce=%b ready=%b want 0 0", bus.ram_ce, bus.if_ready);
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] expCe      = 8'b0110_0110;
      logic [7:0] expMemRdy  = 8'b0000_1000;
      logic [7:0] expIfRdy   = 8'b1000_0000;
      logic [4:0] expStall [8] = '{5'b01111, 5'b01111, 5'b01111, 5'b00011,
                                    5'b00011, 5'b00011, 5'b00011, 5'b00000};
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'h8;
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h100;
      bus.ram_rdata = 32'h12345678;
      #1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) tick();
         total++;
         if (bus.ram_ce !== expCe[c]) begin
            bad++;
            $display("[TB] FAIL simul_ce cycle %0d: got %b want %b", c, bus.ram_ce, expCe[c]);
         end
         total++;
         if (bus.mem_ready !== expMemRdy[c] || bus.if_ready !== expIfRdy[c]) begin
            bad++;
            $display("[TB] FAIL simul_ready cycle %0d: got mem=%b if=%b want mem=%b if=%b",
                     c, bus.mem_ready, bus.if_ready, expMemRdy[c], expIfRdy[c]);
         end
         total++;
         if (bus.stall_o !== expStall[c]) begin
            bad++;
            $display("[TB] FAIL simul_stall cycle %0d: got %b want %b", c, bus.stall_o, expStall[c]);
         end
         if (expCe[c]) begin
            total++;
            if (bus.ram_addr !== ((c < 4) ? 32'h100 : 32'h8)) begin
               bad++;
               $display("[TB] FAIL simul_addr cycle %0d: got %h want %h", c, bus.ram_addr,
                        (c < 4) ? 32'h100 : 32'h8);
            end
         end
         if (c == 3) begin
            total++;
            if (bus.mem_rdata !== 32'h12345678) begin
               bad++;
               $display("[TB] FAIL simul_mem_rdata: got %h want 12345678", bus.mem_rdata);
            end
            bus.mem_req   = 1'b0;
            bus.ram_rdata = 32'hAABBCCDD;
         end
      end
      total++;
      if (bus.if_rdata !== 32'hAABBCCDD || bus.mem_rdata !== 32'h12345678) begin
         bad++;
         $display("[TB] FAIL simul_if_rdata: got if=%h mem=%h want if=aabbccdd mem=12345678",
                  bus.if_rdata, bus.mem_rdata);
      end
      bus.if_req = 1'b0;
      tick();
   endtask

   task automatic test_store();
      logic [3:0] expCe = 4'b0110;
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_sel   = 4'b0011;
      bus.mem_addr  = 32'h200;
      bus.mem_wdata = 32'hDEADBEEF;
      bus.ram_rdata = 32'h55555555;
      #1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         total++;
         if (bus.ram_ce !== expCe[c] || bus.ram_we !== expCe[c]) begin
            bad++;
            $display("[TB] FAIL store_ce_we cycle %0d: got ce=%b we=%b want %b %b",
                     c, bus.ram_ce, bus.ram_we, expCe[c], expCe[c]);
         end
         if (expCe[c]) begin
            total++;
            if (bus.ram_addr !== 32'h200 || bus.ram_wdata !== 32'hDEADBEEF || bus.ram_sel !== 4'b0011) begin
               bad++;
               $display("[TB] FAIL store_bus cycle %0d: got addr=%h wdata=%h sel=%b want 00000200 deadbeef 0011",
                        c, bus.ram_addr, bus.ram_wdata, bus.ram_sel);
            end
         end
      end
      total++;
      if (bus.mem_ready !== 1'b1 || bus.mem_rdata !== 32'h12345678) begin
         bad++;
         $display("[TB] FAIL store_resp: got ready=%b rdata=%h want ready=1 rdata=12345678",
                  bus.mem_ready, bus.mem_rdata);
      end
      total++;
      if (bus.ram_addr !== 32'h200) begin
         bad++;
         $display("[TB] FAIL store_addr_hold: got %h want 00000200", bus.ram_addr);
      end
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      tick();
      total++;
      if (bus.mem_ready !== 1'b0 || bus.ram_we !== 1'b0) begin
         bad++;
         $display("[TB] FAIL store_pulse_width: got ready=%b we=%b want 0 0", bus.mem_ready, bus.ram_we);
      end
   endtask

   task automatic test_late_mem();
      logic [7:0] expCe     = 8'b0110_0110;
      logic [7:0] expIfRdy  = 8'b0000_1000;
      logic [7:0] expMemRdy = 8'b1000_0000;
      logic [4:0] expStall [8] = '{5'b00011, 5'b00011, 5'b01111, 5'b01111,
                                    5'b01111, 5'b01111, 5'b01111, 5'b00000};
      bus.if_req    = 1'b1;
      bus.if_addr   = 32'hC;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h300;
      bus.ram_rdata = 32'h11112222;
      #1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) tick();
         if (c == 2) begin
            bus.mem_req = 1'b1;
            #1;
         end
         total++;
         if (bus.ram_ce !== expCe[c]) begin
            bad++;
            $display("[TB] FAIL late_ce cycle %0d: got %b want %b", c, bus.ram_ce, expCe[c]);
         end
         total++;
         if (bus.if_ready !== expIfRdy[c] || bus.mem_ready !== expMemRdy[c]) begin
            bad++;
            $display("[TB] FAIL late_ready cycle %0d: got if=%b mem=%b want if=%b mem=%b",
                     c, bus.if_ready, bus.mem_ready, expIfRdy[c], expMemRdy[c]);
         end
         total++;
         if (bus.stall_o !== expStall[c]) begin
            bad++;
            $display("[TB] FAIL late_stall cycle %0d: got %b want %b", c, bus.stall_o, expStall[c]);
         end
         if (expCe[c]) begin
            total++;
            if (bus.ram_addr !== ((c < 4) ? 32'hC : 32'h300) || bus.ram_we !== 1'b0) begin
               bad++;
               $display("[TB] FAIL late_addr cycle %0d: got addr=%h we=%b want %h we=0", c,
                        bus.ram_addr, bus.ram_we, (c < 4) ? 32'hC : 32'h300);
            end
         end
         if (c == 3) begin
            total++;
            if (bus.if_rdata !== 32'h11112222) begin
               bad++;
               $display("[TB] FAIL late_if_rdata: got %h want 11112222", bus.if_rdata);
            end
            bus.if_req    = 1'b0;
            bus.ram_rdata = 32'h33334444;
         end
      end
      total++;
      if (bus.mem_rdata !== 32'h33334444) begin
         bad++;
         $display("[TB] FAIL late_mem_rdata: got %h want 33334444", bus.mem_rdata);
      end
      bus.mem_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_access();
      int readySeen = 0;
      bus.mem_req   = 1'b1;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h400;
      bus.ram_rdata = 32'h77778888;
      tick();
      total++;
      if (bus.ram_ce !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rstmid_first_acc: got ce=%b want 1", bus.ram_ce);
      end
      rst = 1'b0;
      tick();
      total++;
      if (bus.ram_ce !== 1'b0 || bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0 || bus.stall_o !== 5'b0) begin
         bad++;
         $display("[TB] FAIL rstmid_abandon: got ce=%b ready=%b rdata=%h stall=%b want 0 0 00000000 00000",
                  bus.ram_ce, bus.mem_ready, bus.mem_rdata, bus.stall_o);
      end
      rst = 1'b1;
      for (int c = 3; c <= 5; c++) begin
         tick();
         if (c < 5) begin
            if (bus.mem_ready) readySeen++;
            total++;
            if (bus.ram_ce !== 1'b1 || bus.ram_addr !== 32'h400) begin
               bad++;
               $display("[TB] FAIL rstmid_retry cycle %0d: got ce=%b addr=%h want 1 00000400",
                        c, bus.ram_ce, bus.ram_addr);
            end
         end
      end
      total++;
      if (readySeen != 0 || bus.mem_ready !== 1'b1 || bus.mem_rdata !== 32'h77778888) begin
         bad++;
         $display("[TB] FAIL rstmid_ready: early=%0d ready=%b rdata=%h want early=0 ready=1 rdata=77778888",
                  readySeen, bus.mem_ready, bus.mem_rdata);
      end
      bus.mem_req = 1'b0;
      tick();
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst           = 1'b0;
      bus.if_req    = 1'b0;
      bus.if_addr   = 32'h0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      bus.mem_sel   = 4'h0;
      bus.ram_rdata = 32'h0;
      test_reset();
      test_fetch();
      test_simultaneous();
      test_store();
      test_late_mem();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
